// File: rtl/sfx_sequencer.sv
// sfx_sequencer: queues sound-effect requests and drives APU saw/square/noise
// trigger levels for a requested number of video frames, starting and ending
// on frame boundaries derived from the beam position.
// Optional build macro SFX_PREEMPT_EN: an urgent request flushes the queue,
// aborts the current sound and re-arms with the urgent request.
module sfx_sequencer #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned DUR_BITS    = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [9:0]                         x,
  input  logic [9:0]                         y,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_id,
  input  logic [DUR_BITS-1:0]                req_dur,
  input  logic                               req_urgent,
  output logic                               saw_trigger,
  output logic                               square_trigger,
  output logic                               noise_trigger,
  output logic                               busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [1:0]          id;
    logic [DUR_BITS-1:0] dur;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2
  } state_e;

  // Trigger pattern {noise, square, saw} for a request id; id 3 is saw+noise.
  function automatic logic [2:0] id_pattern(input logic [1:0] id);
    case (id)
      2'd0:    id_pattern = 3'b001;
      2'd1:    id_pattern = 3'b010;
      2'd2:    id_pattern = 3'b100;
      default: id_pattern = 3'b101;
    endcase
  endfunction

  // A zero duration plays for one frame.
  function automatic logic [DUR_BITS-1:0] norm_dur(input logic [DUR_BITS-1:0] d);
    norm_dur = (d == '0) ? DUR_BITS'(1) : d;
  endfunction

  state_e               state_q, state_d;
  logic                 origin_q, origin_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [1:0]           cur_id_q, cur_id_d;
  logic [DUR_BITS-1:0]  rem_q, rem_d;
  logic [2:0]           trig_q, trig_d;
  req_t                 mem_q [QUEUE_DEPTH];

  logic at_origin;
  logic frame_tick;
  logic full;
  logic empty;
  logic push;
  logic fifo_push;
  logic urgent_push;
  logic pop;
  req_t head;
  req_t new_req;

  assign at_origin  = (x == 10'd0) && (y == 10'd0);
  assign frame_tick = at_origin && !origin_q;
  assign origin_d   = at_origin;

  assign full    = (count_q == CNT_W'(QUEUE_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign new_req = '{id: req_id, dur: req_dur};
  assign push    = req_valid && req_ready;

`ifdef SFX_PREEMPT_EN
  assign req_ready   = !full || req_urgent;
  assign urgent_push = push && req_urgent;
`else
  logic unused_urgent;
  assign unused_urgent = req_urgent;
  assign req_ready     = !full;
  assign urgent_push   = 1'b0;
`endif

  // Urgent requests bypass the queue and are loaded straight into the player.
  assign fifo_push = push && !urgent_push;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      origin_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_id_q <= '0;
      rem_q    <= '0;
      trig_q   <= '0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_id_q <= cur_id_d;
      rem_q    <= rem_d;
      trig_q   <= trig_d;
    end
  end

  // Request storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= new_req;
    end
  end

  // Next-state and FIFO pop decision.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (frame_tick) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (frame_tick && (rem_q == DUR_BITS'(1))) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (urgent_push) begin
      pop     = 1'b0;
      state_d = S_ARM;
    end
  end

  // Trigger levels and current-sound bookkeeping.
  always_comb begin
    trig_d   = 3'b000;
    cur_id_d = cur_id_q;
    rem_d    = rem_q;
    if (pop) begin
      cur_id_d = head.id;
      rem_d    = norm_dur(head.dur);
    end
    case (state_q)
      S_ARM: begin
        if (frame_tick) begin
          trig_d = id_pattern(cur_id_q);
        end
      end
      S_PLAY: begin
        trig_d = id_pattern(cur_id_q);
        if (frame_tick) begin
          if (rem_q > DUR_BITS'(1)) begin
            rem_d = rem_q - DUR_BITS'(1);
          end else if (pop) begin
            trig_d = id_pattern(head.id);
          end else begin
            trig_d = 3'b000;
          end
        end
      end
      default: trig_d = 3'b000;
    endcase
    if (urgent_push) begin
      cur_id_d = new_req.id;
      rem_d    = norm_dur(new_req.dur);
      trig_d   = 3'b000;
    end
  end

  // Queue pointers and occupancy; an urgent request empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(fifo_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(fifo_push) - CNT_W'(pop);
    if (urgent_push) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  assign saw_trigger    = trig_q[0];
  assign square_trigger = trig_q[1];
  assign noise_trigger  = trig_q[2];
  assign busy           = (state_q != S_IDLE) || !empty;
  assign queue_count    = count_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Testbench for sfx_sequencer: an 8-cycle frame (x 0..3, y 0..1) is swept by
// the bench; single-request vectors are table driven, queue/reset/urgent
// corner cases are hand-written sequences.
module tb_sfx_sequencer;

  localparam int FRAME = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x = 10'd1;
  logic [9:0] y = 10'd1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_id = 2'd0;
  logic [5:0] req_dur = 6'd0;
  logic       req_urgent = 1'b0;
  logic       saw_trigger;
  logic       square_trigger;
  logic       noise_trigger;
  logic       busy;
  logic [2:0] queue_count;

  int beam_pos = 5;
  int checks = 0;
  int failures = 0;

  sfx_sequencer #(.QUEUE_DEPTH(4), .DUR_BITS(6)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_dur(req_dur), .req_urgent(req_urgent),
    .saw_trigger(saw_trigger), .square_trigger(square_trigger),
    .noise_trigger(noise_trigger), .busy(busy), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [5:0] dur;
    int         exp_pat;
    int         exp_frames;
  } vec_t;

  vec_t vecs[6];

  function automatic int tv();
    return int'({noise_trigger, square_trigger, saw_trigger});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; inputs (including the beam) change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    beam_pos = (beam_pos + 1) % FRAME;
    x = 10'(beam_pos % 4);
    y = 10'(beam_pos / 4);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < FRAME && beam_pos != p; i++) cyc();
  endtask

  task automatic push(input logic [1:0] id, input logic [5:0] dur, input logic urg);
    check("push_ready", int'(req_ready), 1);
    req_valid = 1'b1; req_id = id; req_dur = dur; req_urgent = urg;
    cyc();
    req_valid = 1'b0; req_urgent = 1'b0;
  endtask

  // Triggers must equal pat for n consecutive cycles starting now.
  task automatic expect_pattern(input string name, input int pat, input int n);
    int got;
    got = pat;
    for (int i = 0; i < n; i++) begin
      if (tv() != pat && got == pat) got = tv();
      cyc();
    end
    check(name, got, pat);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    int w;
    int h;
    int pat;
    vecs[0] = '{id: 2'd0, dur: 6'd3, exp_pat: 1, exp_frames: 3};
    vecs[1] = '{id: 2'd1, dur: 6'd2, exp_pat: 2, exp_frames: 2};
    vecs[2] = '{id: 2'd2, dur: 6'd1, exp_pat: 4, exp_frames: 1};
    vecs[3] = '{id: 2'd3, dur: 6'd0, exp_pat: 5, exp_frames: 1};
    vecs[4] = '{id: 2'd3, dur: 6'd4, exp_pat: 5, exp_frames: 4};
    vecs[5] = '{id: 2'd2, dur: 6'd6, exp_pat: 4, exp_frames: 6};

    #1;
    do_reset();
    check("reset_trig", tv(), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(queue_count), 0);
    check("reset_ready", int'(req_ready), 1);

    // Single requests pushed mid-frame while idle.
    for (int v = 0; v < 6; v++) begin
      wait_pos(3);
      push(vecs[v].id, vecs[v].dur, 1'b0);
      w = 0;
      while (tv() == 0 && w < 40) begin cyc(); w++; end
      check("vec_rise_wait", w, 5);
      check("vec_rise_pos", beam_pos, 1);
      check("vec_pattern", tv(), vecs[v].exp_pat);
      pat = tv();
      h = 0;
      while (tv() == pat && pat != 0 && h < 600) begin cyc(); h++; end
      check("vec_hold_cycles", h, vecs[v].exp_frames * FRAME);
      check("vec_end_trig", tv(), 0);
      check("vec_end_busy", int'(busy), 0);
    end

    // Push in the frame_tick cycle: no same-frame start.
    wait_pos(0);
    push(2'd1, 6'd1, 1'b0);
    w = 0;
    while (tv() == 0 && w < 40) begin cyc(); w++; end
    check("tick_push_wait", w, 8);
    expect_pattern("tick_push_play", 2, 8);
    check("tick_push_done", tv(), 0);

    // Back-to-back: square 2 frames then noise 1 frame, no gap.
    wait_pos(3);
    push(2'd1, 6'd2, 1'b0);
    push(2'd2, 6'd1, 1'b0);
    check("b2b_count_a", int'(queue_count), 1);
    expect_pattern("b2b_arm", 0, 4);
    check("b2b_count_b", int'(queue_count), 1);
    expect_pattern("b2b_square", 2, 16);
    check("b2b_count_c", int'(queue_count), 0);
    expect_pattern("b2b_noise", 4, 8);
    expect_pattern("b2b_idle", 0, 8);
    check("b2b_busy", int'(busy), 0);

    // Queue full: four held while the first plays, fifth waits for a pop.
    wait_pos(2);
    push(2'd0, 6'd1, 1'b0);
    cyc();
    push(2'd1, 6'd1, 1'b0);
    push(2'd2, 6'd1, 1'b0);
    push(2'd3, 6'd1, 1'b0);
    push(2'd0, 6'd1, 1'b0);
    check("full_count", int'(queue_count), 4);
    check("full_ready", int'(req_ready), 0);
    req_valid = 1'b1; req_id = 2'd1; req_dur = 6'd1;
    w = 0;
    while (!req_ready && w < 40) begin cyc(); w++; end
    cyc();
    req_valid = 1'b0;
    check("full_wait", w, 9);
    check("full_count_after", int'(queue_count), 4);
    expect_pattern("full_p1", 2, 7);
    expect_pattern("full_p2", 4, 8);
    expect_pattern("full_p3", 5, 8);
    expect_pattern("full_p4", 1, 8);
    expect_pattern("full_p5", 2, 8);
    expect_pattern("full_idle", 0, 8);
    check("full_busy", int'(busy), 0);

    // Reset while playing with two queued.
    wait_pos(3);
    push(2'd0, 6'd5, 1'b0);
    push(2'd1, 6'd1, 1'b0);
    push(2'd2, 6'd1, 1'b0);
    wait_pos(3);
    check("rst_playing", tv(), 1);
    check("rst_queued", int'(queue_count), 2);
    reset = 1'b1;
    cyc();
    check("rst_trig", tv(), 0);
    check("rst_count", int'(queue_count), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    expect_pattern("rst_no_replay", 0, 24);

    // Urgent request while a long saw plays with three queued.
    wait_pos(2);
    push(2'd0, 6'd10, 1'b0);
    cyc();
    push(2'd1, 6'd1, 1'b0);
    push(2'd1, 6'd1, 1'b0);
    push(2'd1, 6'd1, 1'b0);
    check("urg_busy_arm", int'(busy), 1);
    wait_pos(3);
    check("urg_saw_on", tv(), 1);
    push(2'd2, 6'd1, 1'b1);
`ifdef SFX_PREEMPT_EN
    check("urg_count", int'(queue_count), 0);
    expect_pattern("urg_gap", 0, 5);
    expect_pattern("urg_noise", 4, 8);
    expect_pattern("urg_idle", 0, 16);
`else
    check("urg_count", int'(queue_count), 4);
    expect_pattern("urg_saw_rest", 1, 77);
    expect_pattern("urg_square", 2, 24);
    expect_pattern("urg_noise", 4, 8);
    expect_pattern("urg_idle", 0, 8);
`endif
    check("urg_busy_end", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
